// File: rtl/ccg_bist_pkg.sv
// ---------------------------------------------------------------------------
// ccg_bist_pkg
// Shared definitions for the combinational-benchmark BIST slice: the
// response-compactor FSM encoding and the default MISR/LFSR constants that
// both the response MISR and the upstream pattern generator use.
// ---------------------------------------------------------------------------
package ccg_bist_pkg;

    // Default geometry of the compacted response stream.
    localparam int unsigned CCG_RESP_W = 22;
    localparam int unsigned CCG_SIG_W  = 32;
    localparam int unsigned CCG_CNT_W  = 16;

    // CRC-32 generator (x^32 implicit) and all-ones start value.
    localparam logic [CCG_SIG_W-1:0] CCG_POLY = 32'h04C11DB7;
    localparam logic [CCG_SIG_W-1:0] CCG_SEED = 32'hFFFF_FFFF;

    // Compactor run phases.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ccg_state_e;

endpackage : ccg_bist_pkg

// File: rtl/ccg_misr_step.sv
// ---------------------------------------------------------------------------
// ccg_misr_step
// Purely combinational next-state function of a Galois-style multiple-input
// signature register: shift left, fold the polynomial back in when the MSB
// falls out, then XOR in the parallel data word. With data tied to zero it
// is a plain LFSR step, which is how the pattern generator reuses it.
//
// Ports
//   sig_cur     in   SIG_W  present signature
//   data        in   SIG_W  parallel input word (already zero-extended)
//   sig_next_c  out  SIG_W  next signature (combinational)
// ---------------------------------------------------------------------------
module ccg_misr_step
    import ccg_bist_pkg::*;
#(
    parameter int unsigned      SIG_W = CCG_SIG_W,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(CCG_POLY)
) (
    input  logic [SIG_W-1:0] sig_cur,
    input  logic [SIG_W-1:0] data,
    output logic [SIG_W-1:0] sig_next_c
);

    // Shift, conditional polynomial feedback, then data injection.
    always_comb begin
        sig_next_c = {sig_cur[SIG_W-2:0], 1'b0};
        if (sig_cur[SIG_W-1]) begin
            sig_next_c = sig_next_c ^ POLY;
        end
        sig_next_c = sig_next_c ^ data;
    end

endmodule : ccg_misr_step

// File: rtl/ccg_response_misr.sv
// ---------------------------------------------------------------------------
// ccg_response_misr
// Compacts the per-pattern output vectors of a benchmark circuit into a
// signature. A run opens with start, accepts one beat per cycle while in
// RUN, and closes on the beat flagged resp_last. The signature and beat
// count are then held with sig_valid until the consumer acknowledges.
//
// Optional feature (macro CCG_MISR_ONES_CNT_EN): when defined, ones_cnt
// accumulates the number of 1-bits seen across accepted beats (saturating).
// When undefined, ones_cnt is tied to zero and no popcount logic exists.
//
// Ports
//   clk         in   1         clock, rising edge
//   rst         in   1         synchronous active-high reset
//   start       in   1         open a run (IDLE only)
//   abort       in   1         drop back to IDLE, discard run; highest priority
//   resp_valid  in   1         response beat present
//   resp_data   in   RESP_W    circuit outputs f1 (bit 0) .. fN
//   resp_last   in   1         final beat of the run
//   resp_ready  out  1         beat accepted on resp_valid & resp_ready
//   sig         out  SIG_W     current / final signature
//   sig_valid   out  1         final signature held for the consumer
//   sig_ack     in   1         consumer has taken the signature
//   vec_cnt     out  CNT_W     accepted beats this run (saturating)
//   cnt_ovf     out  1         vec_cnt saturated this run
//   ones_cnt    out  CNT_W+5   accumulated 1-bits (optional feature)
// ---------------------------------------------------------------------------
module ccg_response_misr
    import ccg_bist_pkg::*;
#(
    parameter int unsigned      RESP_W = CCG_RESP_W,
    parameter int unsigned      SIG_W  = CCG_SIG_W,
    parameter logic [SIG_W-1:0] POLY   = SIG_W'(CCG_POLY),
    parameter logic [SIG_W-1:0] SEED   = SIG_W'(CCG_SEED),
    parameter int unsigned      CNT_W  = CCG_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 resp_valid,
    input  logic [RESP_W-1:0]    resp_data,
    input  logic                 resp_last,
    output logic                 resp_ready,
    output logic [SIG_W-1:0]     sig,
    output logic                 sig_valid,
    input  logic                 sig_ack,
    output logic [CNT_W-1:0]     vec_cnt,
    output logic                 cnt_ovf,
    output logic [CNT_W+4:0]     ones_cnt
);

    localparam int unsigned ONES_W = CNT_W + 5;

    // The response word is zero-extended into the signature, so it must fit.
    if (RESP_W > SIG_W) begin : g_width_err
        $error("ccg_response_misr: RESP_W must not exceed SIG_W");
    end

    ccg_state_e        state;
    logic              beat_acc_c;
    logic              start_load_c;
    logic [SIG_W-1:0]  data_ext_c;
    logic [SIG_W-1:0]  sig_next_c;

    // Ready is a pure decode of state and abort; it never looks at resp_valid.
    assign resp_ready   = (state == RUN) && !abort;
    assign beat_acc_c   = resp_valid && resp_ready;
    assign start_load_c = (state == IDLE) && start && !abort;
    assign data_ext_c   = SIG_W'(resp_data);

    ccg_misr_step #(
        .SIG_W (SIG_W),
        .POLY  (POLY)
    ) u_step (
        .sig_cur    (sig),
        .data       (data_ext_c),
        .sig_next_c (sig_next_c)
    );

    // Run-control FSM with the signature, beat counter and overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sig_valid <= 1'b0;
            sig       <= '0;
            vec_cnt   <= '0;
            cnt_ovf   <= 1'b0;
        end else if (abort) begin
            // Run is discarded; sig/vec_cnt simply stop updating.
            state     <= IDLE;
            sig_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        sig     <= SEED;
                        vec_cnt <= '0;
                        cnt_ovf <= 1'b0;
                    end
                end
                RUN: begin
                    if (beat_acc_c) begin
                        sig <= sig_next_c;
                        // Saturate; the beat that would wrap raises the flag.
                        if (vec_cnt == {CNT_W{1'b1}}) begin
                            cnt_ovf <= 1'b1;
                        end else begin
                            vec_cnt <= vec_cnt + CNT_W'(1);
                        end
                        if (resp_last) begin
                            state     <= DONE;
                            sig_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (sig_ack) begin
                        state     <= IDLE;
                        sig_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    sig_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef CCG_MISR_ONES_CNT_EN
    localparam int unsigned POP_W  = $clog2(RESP_W + 1);
    localparam int unsigned SUM_W  = ONES_W + 1;

    logic [POP_W-1:0] pop_c;
    logic [SUM_W-1:0] ones_sum_c;
    logic [ONES_W-1:0] ones_q;

    // Population count of the current response word.
    always_comb begin
        pop_c = '0;
        for (int unsigned i = 0; i < RESP_W; i++) begin
            pop_c = pop_c + POP_W'(resp_data[i]);
        end
    end

    // One spare bit catches the carry that signals saturation.
    assign ones_sum_c = {1'b0, ones_q} + SUM_W'(pop_c);

    // Saturating 1-bit accumulator, cleared when a run opens.
    always_ff @(posedge clk) begin
        if (rst) begin
            ones_q <= '0;
        end else if (start_load_c) begin
            ones_q <= '0;
        end else if (beat_acc_c) begin
            if (ones_sum_c[SUM_W-1]) begin
                ones_q <= {ONES_W{1'b1}};
            end else begin
                ones_q <= ones_sum_c[ONES_W-1:0];
            end
        end
    end

    assign ones_cnt = ones_q;
`else
    // Feature disabled: no popcount hardware, constant output.
    assign ones_cnt = ONES_W'(0);
`endif

endmodule : ccg_response_misr

// File: tb/tb_ccg_response_misr.sv
// ---------------------------------------------------------------------------
// tb_ccg_response_misr
// Two instances share one stimulus stream: u_a uses all defaults, u_b uses
// SEED=0 and CNT_W=4. A small reference model tracks both; per-cycle checks
// cover the handshake, and a scoreboard queue of end-of-run results is
// drained by a monitor whenever sig_valid rises.
// ---------------------------------------------------------------------------
module tb_ccg_response_misr;

`ifdef CCG_MISR_ONES_CNT_EN
    localparam bit ONES_EN = 1'b1;
`else
    localparam bit ONES_EN = 1'b0;
`endif

    localparam logic [31:0] POLY_M = 32'h04C11DB7;

    logic        clk = 1'b0;
    logic        rst, start, abort, resp_valid, resp_last, sig_ack;
    logic [21:0] resp_data;

    logic        ready_a, ready_b, sv_a, sv_b, ovf_a, ovf_b;
    logic [31:0] sig_a, sig_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;
    logic [20:0] ones_a;
    logic [8:0]  ones_b;

    always #5 clk = ~clk;

    ccg_response_misr u_a (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_last(resp_last),
        .resp_ready(ready_a), .sig(sig_a), .sig_valid(sv_a), .sig_ack(sig_ack),
        .vec_cnt(cnt_a), .cnt_ovf(ovf_a), .ones_cnt(ones_a)
    );

    ccg_response_misr #(.SEED(32'h0), .CNT_W(4)) u_b (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_last(resp_last),
        .resp_ready(ready_b), .sig(sig_b), .sig_valid(sv_b), .sig_ack(sig_ack),
        .vec_cnt(cnt_b), .cnt_ovf(ovf_b), .ones_cnt(ones_b)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] sig_a, sig_b;
        logic [15:0] cnt_a;
        logic [3:0]  cnt_b;
        logic        ovf_a, ovf_b;
        logic [20:0] ones_a;
        logic [8:0]  ones_b;
    } exp_t;

    exp_t sb_q[$];

    int          m_state = 0;       // 0 idle, 1 run, 2 done
    logic [31:0] ma_sig = '0, mb_sig = '0;
    logic [15:0] ma_cnt = '0;
    logic [3:0]  mb_cnt = '0;
    logic        ma_ovf = 1'b0, mb_ovf = 1'b0;
    int          ma_ones = 0, mb_ones = 0;

    function automatic logic [31:0] m_step(input logic [31:0] s, input logic [21:0] d);
        logic [31:0] n;
        n = s << 1;
        if (s[31]) n = n ^ POLY_M;
        return n ^ {10'b0, d};
    endfunction

    function automatic exp_t snap();
        exp_t e;
        e.sig_a = ma_sig;  e.sig_b = mb_sig;
        e.cnt_a = ma_cnt;  e.cnt_b = mb_cnt;
        e.ovf_a = ma_ovf;  e.ovf_b = mb_ovf;
        e.ones_a = ONES_EN ? 21'(ma_ones) : 21'd0;
        e.ones_b = ONES_EN ? 9'(mb_ones)  : 9'd0;
        return e;
    endfunction

    task automatic model_edge();
        int p;
        if (rst) begin
            m_state = 0; ma_sig = '0; mb_sig = '0; ma_cnt = '0; mb_cnt = '0;
            ma_ovf = 0; mb_ovf = 0; ma_ones = 0; mb_ones = 0;
        end else if (abort) begin
            m_state = 0;
        end else if (m_state == 0) begin
            if (start) begin
                m_state = 1; ma_sig = 32'hFFFF_FFFF; mb_sig = 32'h0;
                ma_cnt = '0; mb_cnt = '0; ma_ovf = 0; mb_ovf = 0;
                ma_ones = 0; mb_ones = 0;
            end
        end else if (m_state == 1) begin
            if (resp_valid) begin
                ma_sig = m_step(ma_sig, resp_data);
                mb_sig = m_step(mb_sig, resp_data);
                if (ma_cnt == 16'hFFFF) ma_ovf = 1; else ma_cnt = ma_cnt + 16'd1;
                if (mb_cnt == 4'hF) mb_ovf = 1; else mb_cnt = mb_cnt + 4'd1;
                p = $countones(resp_data);
                ma_ones = (ma_ones + p > 2097151) ? 2097151 : ma_ones + p;
                mb_ones = (mb_ones + p > 511) ? 511 : mb_ones + p;
                if (resp_last) begin
                    m_state = 2;
                    sb_q.push_back(snap());
                end
            end
        end else begin
            if (sig_ack) m_state = 0;
        end
    endtask

    // One clock: check ready against current inputs, clock, check registers.
    task automatic step();
        exp_t e;
        #1;
        chk("resp_ready_a", 64'(ready_a), 64'(m_state == 1 && !abort));
        chk("resp_ready_b", 64'(ready_b), 64'(m_state == 1 && !abort));
        @(posedge clk);
        model_edge();
        #1;
        e = snap();
        chk("sig_valid_a", 64'(sv_a), 64'(m_state == 2));
        chk("sig_valid_b", 64'(sv_b), 64'(m_state == 2));
        chk("sig_a", 64'(sig_a), 64'(e.sig_a));
        chk("sig_b", 64'(sig_b), 64'(e.sig_b));
        chk("vec_cnt_a", 64'(cnt_a), 64'(e.cnt_a));
        chk("vec_cnt_b", 64'(cnt_b), 64'(e.cnt_b));
        chk("cnt_ovf_a", 64'(ovf_a), 64'(e.ovf_a));
        chk("cnt_ovf_b", 64'(ovf_b), 64'(e.ovf_b));
        chk("ones_cnt_a", 64'(ones_a), 64'(e.ones_a));
        chk("ones_cnt_b", 64'(ones_b), 64'(e.ones_b));
    endtask

    task automatic quiet();
        start = 0; abort = 0; resp_valid = 0; resp_last = 0; sig_ack = 0; resp_data = '0;
    endtask

    task automatic beat(input logic [21:0] d, input logic last);
        resp_valid = 1; resp_data = d; resp_last = last;
        step();
        resp_valid = 0; resp_last = 0;
    endtask

    task automatic open_run();
        start = 1; step(); start = 0;
    endtask

    task automatic ack_run();
        sig_ack = 1; step(); sig_ack = 0; step();
    endtask

    // ---------------- scoreboard monitor ----------------
    logic sv_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (sv_a && !sv_prev) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_sig_valid", 64'(1), 64'(0));
            end else begin
                e = sb_q.pop_front();
                chk("sb_sig_a", 64'(sig_a), 64'(e.sig_a));
                chk("sb_sig_b", 64'(sig_b), 64'(e.sig_b));
                chk("sb_vec_cnt_a", 64'(cnt_a), 64'(e.cnt_a));
                chk("sb_vec_cnt_b", 64'(cnt_b), 64'(e.cnt_b));
                chk("sb_cnt_ovf_b", 64'(ovf_b), 64'(e.ovf_b));
                chk("sb_ones_a", 64'(ones_a), 64'(e.ones_a));
            end
        end
        sv_prev = sv_a;
    end

    // ---------------- directed stimulus ----------------
    initial begin
        logic [31:0] held;
        int          acc;
        logic        v;
        quiet();
        rst = 1;
        step(); step();
        rst = 0;
        step();
        chk("reset_sig_a", 64'(sig_a), 64'h0);
        chk("reset_ready_a", 64'(ready_a), 64'h0);

        // Single zero beat from the default seed.
        open_run();
        beat(22'h0, 1'b1);
        chk("t1_sig_a_const", 64'(sig_a), 64'hFB3E_E249);
        chk("t1_vec_cnt_const", 64'(cnt_a), 64'd1);
        chk("t1_sig_b_const", 64'(sig_b), 64'h0);
        ack_run();

        // All-ones beat: zero seed gives the word itself.
        open_run();
        beat(22'h3F_FFFF, 1'b1);
        chk("t2_sig_b_const", 64'(sig_b), 64'h003F_FFFF);
        chk("t2_sig_a_const", 64'(sig_a), 64'hFB01_1DB6);
        chk("t2_ones_a_const", 64'(ones_a), ONES_EN ? 64'd22 : 64'd0);
        ack_run();

        // 100 accepted beats with resp_valid toggled randomly.
        open_run();
        acc = 0;
        for (int i = 0; i < 1000 && acc < 100; i++) begin
            v = 1'($urandom_range(0, 1));
            resp_valid = v;
            resp_data  = 22'($urandom);
            resp_last  = v && (acc == 99);
            step();
            if (v) acc++;
        end
        quiet();
        chk("t3_vec_cnt_const", 64'(cnt_a), 64'd100);
        chk("t3_sig_valid", 64'(sv_a), 64'd1);
        ack_run();

        // Counter saturation on the 4-bit instance.
        open_run();
        for (int i = 1; i <= 20; i++) begin
            held = sig_b;
            beat(22'($urandom), i == 20);
            chk("t4_sig_b_moves", 64'(sig_b != held), 64'(m_step(held, resp_data) != held));
            if (i == 15) chk("t4_ovf_b_at15", 64'(ovf_b), 64'd0);
            if (i == 16) chk("t4_ovf_b_at16", 64'(ovf_b), 64'd1);
        end
        chk("t4_vec_cnt_b_const", 64'(cnt_b), 64'd15);
        chk("t4_vec_cnt_a_const", 64'(cnt_a), 64'd20);
        ack_run();

        // Abort mid-run with a beat on offer.
        open_run();
        beat(22'h12345, 1'b0);
        beat(22'h0ABCD, 1'b0);
        held = sig_a;
        resp_valid = 1; resp_data = 22'h3F0F0F; resp_last = 1; abort = 1;
        step();
        quiet();
        chk("t5_sig_a_unchanged", 64'(sig_a), 64'(held));
        step();
        chk("t5_sig_valid_after_abort", 64'(sv_a), 64'd0);
        open_run();
        chk("t5_reseed_a", 64'(sig_a), 64'hFFFF_FFFF);
        chk("t5_reseed_cnt", 64'(cnt_a), 64'd0);
        beat(22'h1, 1'b1);
        ack_run();

        // DONE holds through start pulses until acknowledged.
        open_run();
        beat(22'h2AAAAA, 1'b0);
        beat(22'h155555, 1'b1);
        held = sig_a;
        for (int i = 0; i < 10; i++) begin
            start = i[0];
            step();
        end
        chk("t6_sig_held", 64'(sig_a), 64'(held));
        chk("t6_sig_valid_held", 64'(sv_a), 64'd1);
        start = 1; sig_ack = 1;
        step();
        quiet();
        chk("t6_sig_valid_dropped", 64'(sv_a), 64'd0);
        step();
        chk("t6_start_ignored_ready", 64'(ready_a), 64'd0);

        // Reset in the middle of a run.
        open_run();
        beat(22'h00F00F, 1'b0);
        rst = 1; resp_valid = 1; resp_data = 22'h3FFFFF;
        step();
        quiet();
        rst = 0;
        chk("t7_rst_sig", 64'(sig_a), 64'h0);
        chk("t7_rst_cnt", 64'(cnt_a), 64'h0);
        chk("t7_rst_sig_valid", 64'(sv_a), 64'h0);
        step();

        step();
        chk("sb_queue_drained", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_ccg_response_misr
